dcache_ctrl: RTL and testbench

Direct-mapped, write-back, write-allocate data cache controller between the CPU's data-write (MEM) stage and a slow line-wide backing memory. Hits are served with zero added latency. Misses stall the pipeline through `cpu_stall_o` while a finite state machine writes back a dirty victim line and then refills the requested line over a request/acknowledge handshake. Sign/zero extension and width selection remain in the MEM stage; this block returns whole words.

---
 rtl/dcache_ctrl.sv | 130 +++++++++++++
 tb/tb_dcache_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Hits complete combinationally; misses stall while the FSM writes back a dirty victim and refills.
module dcache_ctrl #(
  parameter int LINES      = 32,
  parameter int LINE_BYTES = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cpu_req_i,
  input  logic                      cpu_we_i,
  input  logic [31:0]               cpu_addr_i,
  input  logic [3:0]                cpu_be_i,
  input  logic [31:0]               cpu_data_i,
  output logic [31:0]               cpu_data_o,
  output logic                      cpu_stall_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [31:0]               mem_addr_o,
  output logic [LINE_BYTES*8-1:0]   mem_data_o,
  input  logic [LINE_BYTES*8-1:0]   mem_data_i,
  input  logic                      mem_ack_i
);

  localparam int IW = $clog2(LINES);
  localparam int OW = $clog2(LINE_BYTES);
  localparam int TW = 32 - IW - OW;
  localparam int LW = LINE_BYTES * 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WB    = 2'd1;
  localparam logic [1:0] S_ALLOC = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [LINES-1:0] valid_q, dirty_q;
  logic [TW-1:0]    tag_q  [LINES];
  logic [LW-1:0]    line_q [LINES];
  logic [TW-1:0]    vtag_q;
  logic [LW-1:0]    vdata_q;

  logic [TW-1:0]    req_tag;
  logic [IW-1:0]    idx;
  logic [OW-3:0]    wsel;
  logic             hit;
  logic             victim_dirty;
  logic [31:0]      rd_word;
  logic [31:0]      wr_word;
  logic             unused_lo;

  assign req_tag      = cpu_addr_i[31:IW+OW];
  assign idx          = cpu_addr_i[IW+OW-1:OW];
  assign wsel         = cpu_addr_i[OW-1:2];
  assign unused_lo    = ^cpu_addr_i[1:0];
  assign hit          = cpu_req_i & valid_q[idx] & (tag_q[idx] == req_tag);
  assign victim_dirty = valid_q[idx] & dirty_q[idx];

  always_comb begin
    rd_word = line_q[idx][wsel*32 +: 32];
    wr_word = rd_word;
    for (int b = 0; b < 4; b++) begin
      if (cpu_be_i[b]) wr_word[b*8 +: 8] = cpu_data_i[b*8 +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cpu_req_i && !hit) state_d = victim_dirty ? S_WB : S_ALLOC;
      S_WB:    if (mem_ack_i) state_d = S_ALLOC;
      S_ALLOC: if (mem_ack_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req_o   = (state_q == S_WB) || (state_q == S_ALLOC);
    mem_we_o    = (state_q == S_WB);
    mem_addr_o  = '0;
    mem_data_o  = '0;
    if (state_q == S_WB) begin
      mem_addr_o = {vtag_q, idx, {OW{1'b0}}};
      mem_data_o = vdata_q;
    end else if (state_q == S_ALLOC) begin
      mem_addr_o = {req_tag, idx, {OW{1'b0}}};
    end
    cpu_stall_o = (state_q != S_IDLE) || (cpu_req_i && !hit);
    cpu_data_o  = (state_q == S_IDLE && hit && !cpu_we_i) ? rd_word : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      dirty_q <= '0;
      vtag_q  <= '0;
      vdata_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (cpu_req_i && !hit && victim_dirty) begin
            vtag_q  <= tag_q[idx];
            vdata_q <= line_q[idx];
          end
          if (hit && cpu_we_i) dirty_q[idx] <= 1'b1;
        end
        S_WB: if (mem_ack_i) dirty_q[idx] <= 1'b0;
        S_ALLOC: begin
          if (mem_ack_i) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays carry no reset; the valid bits qualify them.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_q == S_ALLOC && mem_ack_i) begin
        line_q[idx] <= mem_data_i;
        tag_q[idx]  <= req_tag;
      end else if (state_q == S_IDLE && hit && cpu_we_i) begin
        line_q[idx][wsel*32 +: 32] <= wr_word;
      end
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: a flat-memory golden view plus line occupancy predicts
// memory transfers, stall lengths and load data; a monitor checks them as the DUT presents them.
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_req, cpu_we;
  logic [31:0]  cpu_addr;
  logic [3:0]   cpu_be;
  logic [31:0]  cpu_wdata, cpu_rdata;
  logic         stall, mem_req, mem_we;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata = '0;
  logic         mem_ack = 1'b0;

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
    .cpu_be_i(cpu_be), .cpu_data_i(cpu_wdata), .cpu_data_o(cpu_rdata),
    .cpu_stall_o(stall),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_data_o(mem_wdata), .mem_data_i(mem_rdata), .mem_ack_i(mem_ack)
  );

  typedef struct {
    bit           is_mem;
    bit           we;
    logic [31:0]  addr;
    logic [255:0] line;
    logic [31:0]  word;
    int           stall;
  } exp_t;

  int total = 0;
  int bad   = 0;
  exp_t sb[$];
  int   wait_q[$];
  logic [255:0] bmem [int unsigned];
  logic [31:0]  gold [int unsigned];
  bit           c_valid [32];
  bit           c_dirty [32];
  int unsigned  c_tag   [32];

  function automatic logic [31:0] init_word(int unsigned a);
    return (a * 32'h9E3779B1) ^ (a >> 3) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [255:0] bmem_line(int unsigned la);
    logic [255:0] l;
    if (bmem.exists(la)) return bmem[la];
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = init_word(la + 4*i);
    return l;
  endfunction

  function automatic logic [31:0] gold_word(int unsigned a);
    int unsigned w;
    logic [255:0] l;
    w = a & ~32'd3;
    if (gold.exists(w)) return gold[w];
    l = bmem_line(w & ~32'd31);
    return l[((w >> 2) & 7)*32 +: 32];
  endfunction

  function automatic logic [255:0] gold_line(int unsigned la);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = gold_word(la + 4*i);
    return l;
  endfunction

  task automatic check(string name, logic [255:0] act, logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Backing memory: waits the queued number of cycles, then acks for one cycle.
  int rsp_cnt  = 0;
  bit rsp_busy = 0;
  always @(posedge clk) begin
    #1;
    mem_ack = 1'b0;
    if (mem_req) begin
      if (!rsp_busy) begin
        rsp_busy = 1;
        rsp_cnt  = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
      end
      if (rsp_cnt == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = bmem_line(mem_addr);
        if (mem_we) bmem[mem_addr] = mem_wdata;
        rsp_busy  = 0;
      end else begin
        rsp_cnt--;
      end
    end else begin
      rsp_busy = 0;
    end
  end

  int   stall_cnt = 0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst) begin
      stall_cnt = 0;
    end else begin
      if (mem_req && mem_ack) begin
        if (sb.size() == 0 || !sb[0].is_mem) begin
          total++; bad++;
          $display("FAIL mem_unexpected: got addr %0h we %0b, no transfer expected", mem_addr, mem_we);
        end else begin
          mon_e = sb.pop_front();
          check("mem_we", {255'd0, mem_we}, {255'd0, mon_e.we});
          check("mem_addr", {224'd0, mem_addr}, {224'd0, mon_e.addr});
          if (mon_e.we) check("mem_wb_data", mem_wdata, mon_e.line);
        end
      end
      if (cpu_req && !stall) begin
        if (sb.size() == 0 || sb[0].is_mem) begin
          total++; bad++;
          $display("FAIL done_unexpected: access completed at %0h, expected queue head differs", cpu_addr);
        end else begin
          mon_e = sb.pop_front();
          check("stall_cycles", 256'(stall_cnt), 256'(mon_e.stall));
          if (!cpu_we) check("load_data", {224'd0, cpu_rdata}, {224'd0, mon_e.word});
        end
        stall_cnt = 0;
      end else if (cpu_req) begin
        stall_cnt++;
      end
    end
  end

  task automatic access(bit we, logic [31:0] addr, logic [3:0] be, logic [31:0] wd, int wbw, int alw);
    int unsigned idx, tg, la;
    exp_t e;
    int st;
    bit done;
    logic [31:0] w;
    idx = (addr >> 5) & 31;
    tg  = addr >> 10;
    la  = addr & ~32'd31;
    if (c_valid[idx] && c_tag[idx] == tg) begin
      st = 0;
    end else begin
      if (c_valid[idx] && c_dirty[idx]) begin
        e.is_mem = 1; e.we = 1;
        e.addr   = (c_tag[idx] << 10) | (idx << 5);
        e.line   = gold_line(e.addr);
        e.word = '0; e.stall = 0;
        sb.push_back(e);
        wait_q.push_back(wbw);
        st = 3 + wbw + alw;
      end else begin
        st = 2 + alw;
      end
      e.is_mem = 1; e.we = 0; e.addr = la; e.line = '0; e.word = '0; e.stall = 0;
      sb.push_back(e);
      wait_q.push_back(alw);
      c_valid[idx] = 1; c_tag[idx] = tg; c_dirty[idx] = 0;
    end
    e.is_mem = 0; e.we = we; e.addr = addr; e.line = '0; e.stall = st;
    e.word = gold_word(addr);
    sb.push_back(e);
    if (we) begin
      w = gold_word(addr);
      for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = wd[b*8 +: 8];
      gold[addr & ~32'd3] = w;
      c_dirty[idx] = 1;
    end
    cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_be = be; cpu_wdata = wd;
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (!stall) done = 1;
    end
    if (!done) begin
      $display("FAIL access_timeout: addr %0h still stalled, required completion within 60 cycles", addr);
      total++; bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "access timeout");
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    cpu_req = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic preset(logic [31:0] a, logic [31:0] v);
    logic [255:0] l;
    l = bmem_line(a & ~32'd31);
    l[a[4:2]*32 +: 32] = v;
    bmem[a & ~32'd31] = l;
    gold[a & ~32'd3] = v;
  endtask

  initial begin
    rst = 1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_be = '0; cpu_wdata = '0;
    repeat (2) @(posedge clk);
    #1; rst = 0;
    check("rst_mem_req", {255'd0, mem_req}, 256'd0);
    check("rst_mem_we", {255'd0, mem_we}, 256'd0);
    check("rst_mem_addr", {224'd0, mem_addr}, 256'd0);
    check("rst_mem_data", mem_wdata, 256'd0);
    check("rst_stall_idle", {255'd0, stall}, 256'd0);
    check("rst_cpu_data", {224'd0, cpu_rdata}, 256'd0);
    cpu_req = 1; cpu_addr = 32'h40;
    #1;
    check("rst_stall_on_miss", {255'd0, stall}, 256'd1);
    cpu_req = 0;
    @(posedge clk); #1;

    preset(32'h48, 32'hDEADBEEF);
    access(0, 32'h40, 4'h0, 32'h0, 0, 3);
    access(0, 32'h48, 4'h0, 32'h0, 0, 0);
    access(1, 32'h48, 4'b0101, 32'h11223344, 0, 0);
    access(0, 32'h48, 4'h0, 32'h0, 0, 0);
    check("merged_word_model", {224'd0, gold_word(32'h48)}, {224'd0, 32'hDE22BE44});
    access(0, 32'h440, 4'h0, 32'h0, 1, 2);
    access(0, 32'h1004, 4'h0, 32'h0, 0, 0);

    // Reset while a refill is outstanding.
    wait_q.push_back(10);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h48; cpu_be = 4'h0;
    repeat (3) begin @(posedge clk); #1; end
    check("alloc_req", {255'd0, mem_req}, 256'd1);
    check("alloc_we", {255'd0, mem_we}, 256'd0);
    check("alloc_addr", {224'd0, mem_addr}, 256'h40);
    rst = 1; cpu_req = 0;
    @(posedge clk); #1;
    rst = 0;
    check("midrst_mem_req", {255'd0, mem_req}, 256'd0);
    check("midrst_stall", {255'd0, stall}, 256'd0);
    for (int i = 0; i < 32; i++) begin c_valid[i] = 0; c_dirty[i] = 0; end
    gold.delete();
    wait_q.delete();
    sb.delete();
    access(0, 32'h48, 4'h0, 32'h0, 0, 1);
    access(0, 32'h1004, 4'h0, 32'h0, 0, 2);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 5) |
          ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      access(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end

    idle(4);
    check("scoreboard_drained", 256'(sb.size()), 256'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
